signed_dot_mac: RTL and testbench
=================================

SIGNED_DOT_MAC -- requirements
Module: signed_dot_mac

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (all state updates on rising edge) and reset.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the signed operand width.
REQ-003 The block SHALL have parameter VEC_LEN, default 4, meaning the elements per dot product (>=1).
REQ-004 The block SHALL have parameter ACC_W, default 24, meaning the accumulator width; it SHALL be >= 2*DATA_W + clog2(VEC_LEN)+1, checked at elaboration.
REQ-005 The block SHALL have parameter OUT_W, default 16, meaning the result width (OUT_W <= ACC_W).
REQ-006 The block SHALL have parameter SHIFT, default 0, meaning the arithmetic right shift applied to the sum before saturation.
REQ-007 Port clk: input, 1 bit, clock.
REQ-008 Port reset: input, 1 bit, synchronous active-high reset.
REQ-009 Port in_valid: input, 1 bit, operand pair valid.
REQ-010 Port in_ready: output, 1 bit, block accepts an operand pair.
REQ-011 Port a: input, DATA_W bits, signed operand.
REQ-012 Port b: input, DATA_W bits, signed operand.
REQ-013 Port out_valid: output, 1 bit, result valid.
REQ-014 Port out_ready: input, 1 bit, consumer accepts result.
REQ-015 Port out_data: output, OUT_W bits, signed dot-product result.
REQ-016 Port out_sat: output, 1 bit, out_data was clamped.

Function
REQ-017 An element SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-018 The product a*b SHALL be formed as a full 2*DATA_W signed product, sign-extended to ACC_W, with no truncation.
REQ-019 The FSM SHALL have states ACC, FLUSH and OUT, and in_ready SHALL be 1 only in ACC; it SHALL be a function of registered state only.
REQ-020 In ACC, each accept SHALL register the product at the accepting edge, and the accumulator SHALL add that registered product on the following edge.
REQ-021 In ACC, an element counter SHALL increment on each accept; on an accept with counter == VEC_LEN-1, the counter SHALL clear and the FSM SHALL go to FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle; on its exit edge, out_data/out_sat SHALL load from the complete sum, the accumulator SHALL clear, and the FSM SHALL go to OUT.
REQ-023 Latency SHALL be that out_valid is high in the second cycle after the edge accepting the last element (2 edges).
REQ-024 Rounding SHALL be: if SHIFT > 0, add 2^(SHIFT-1) to the sum, then arithmetic-shift right by SHIFT (round half toward +inf); if SHIFT = 0, no rounding.
REQ-025 Saturation SHALL clamp the shifted value to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat SHALL be 1 if clamping occurred and 0 otherwise.
REQ-026 The computation width SHALL be ACC_W+1 for the rounding add, so that no internal wrap is possible.
REQ-027 In OUT, out_valid SHALL be 1, and out_data/out_sat SHALL be held stable until an edge with out_ready=1, after which out_valid SHALL be 0 and the FSM SHALL return to ACC.
REQ-028 in_valid SHALL be ignored outside ACC, and a/b SHALL be ignored when not accepted.
REQ-029 In ACC, out_valid SHALL be 0; out_data SHALL retain its last value.
REQ-030 For VEC_LEN = 1, every accept SHALL go straight to FLUSH.

Reset
REQ-031 While reset is high at an edge: state SHALL go to ACC, the counter, accumulator and product register SHALL be 0, out_valid SHALL be 0, out_data SHALL be 0, out_sat SHALL be 0, and in_ready SHALL be 0 during the reset cycle.
REQ-032 Reset SHALL take priority over any simultaneous accept or output handshake.
REQ-033 Reset mid-vector or in FLUSH/OUT SHALL discard the partial sum and pending result.
REQ-034 The first cycle after reset deassertion SHALL have in_ready = 1.

Verification (defaults unless stated)
REQ-035 Basic: a={-5,-128,20,1}, b={10,-1,15,0} back-to-back -> out_valid 2 edges after the 4th accept, with out_data=378 and out_sat=0.
REQ-036 Saturation: four pairs (-128,-128) -> out_data=32767, out_sat=1; four pairs (-128,127) -> out_data=-32768, out_sat=1.
REQ-037 Rounding with SHIFT=4 and VEC_LEN=1: (4,6) -> 2; (-4,6) -> -1; (1,8) -> 1; out_sat=0 in all cases.
REQ-038 Backpressure: out_ready held 0 for 3 cycles in OUT -> out_data is stable, out_valid=1 and in_ready=0 throughout; in_valid pulses in this window are not accepted; the result clears 1 edge after out_ready=1.
REQ-039 Reset mid-vector: accept (100,100) twice, then assert reset for 1 cycle, then a={1,2,3,4}, b={1,1,1,1} -> out_data=10.
REQ-040 Gapped input: in_valid toggling 1/0 across a vector -> same result as back-to-back, and the counter advances only on accepts.

Source files
------------

// File: rtl/signed_dot_mac.sv
// Signed dot-product MAC.
// Multiplies streaming operand pairs, accumulates VEC_LEN products,
// then rounds, shifts and saturates the sum into a held result.
module signed_dot_mac #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int EXT_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    // Rounding constant 2^(SHIFT-1), which collapses to zero when SHIFT is 0.
    localparam logic [EXT_W:0]   RND_FULL = (EXT_W + 1)'(1) << SHIFT;
    localparam logic [EXT_W-1:0] RND      = RND_FULL[EXT_W:1];

    // Output clamp limits expressed in the widened computation width.
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Reject parameter sets where the accumulator could overflow or the output is wider than the sum.
    generate
        if (VEC_LEN < 1) begin : g_bad_len
            $error("signed_dot_mac: VEC_LEN must be at least 1");
        end
        if (ACC_W < 2 * DATA_W + $clog2(VEC_LEN) + 1) begin : g_bad_acc
            $error("signed_dot_mac: ACC_W too narrow for DATA_W and VEC_LEN");
        end
        if (OUT_W > ACC_W) begin : g_bad_out
            $error("signed_dot_mac: OUT_W must not exceed ACC_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   prod_q, prod_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic                      accept;
    logic signed [2*DATA_W-1:0] prod_full;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [EXT_W-1:0]   sum_rnd;
    logic signed [EXT_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   sat_data;
    logic                      sat_flag;

    assign in_ready  = (state_q == ACC) && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    assign prod_full = a * b;
    assign prod_ext  = {{(ACC_W - 2 * DATA_W){prod_full[2*DATA_W-1]}}, prod_full};

    // The last product is still in prod_q when FLUSH runs, so the complete sum includes it.
    assign sum     = acc_q + prod_q;
    assign sum_rnd = {sum[ACC_W-1], sum} + RND;
    assign shifted = sum_rnd >>> SHIFT;

    // Clamp the rounded, shifted sum into the signed output range and flag any clamping.
    always_comb begin
        sat_data = shifted[OUT_W-1:0];
        sat_flag = 1'b0;
        if (shifted > MAX_V) begin
            sat_data = MAX_V[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (shifted < MIN_V) begin
            sat_data = MIN_V[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end

    // Next-state logic: accumulate in ACC, capture the result in FLUSH, hold it in OUT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        prod_d     = '0;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ACC: begin
                acc_d = sum;
                if (accept) begin
                    prod_d = prod_ext;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                out_data_d = sat_data;
                out_sat_d  = sat_flag;
                acc_d      = '0;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset wins over any handshake in the same cycle and drops partial work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACC;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_signed_dot_mac.sv
// Bench for signed_dot_mac: a default-parameter instance plus a
// VEC_LEN=1 / SHIFT=4 instance for rounding, checked through result queues.
module tb_signed_dot_mac;

    typedef struct packed {
        logic signed [15:0] data;
        logic               sat;
    } exp_t;

    typedef logic signed [7:0] vec_t [4];

    logic clk;
    logic reset;

    logic              inValid0, inReady0, outValid0, outReady0, outSat0;
    logic signed [7:0] aIn0, bIn0;
    logic signed [15:0] outData0;

    logic              inValid1, inReady1, outValid1, outReady1, outSat1;
    logic signed [7:0] aIn1, bIn1;
    logic signed [15:0] outData1;

    exp_t q0[$];
    exp_t q1[$];

    int checks;
    int errors;

    vec_t va;
    vec_t vb;

    signed_dot_mac dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid0),
        .in_ready  (inReady0),
        .a         (aIn0),
        .b         (bIn0),
        .out_valid (outValid0),
        .out_ready (outReady0),
        .out_data  (outData0),
        .out_sat   (outSat0)
    );

    signed_dot_mac #(
        .VEC_LEN (1),
        .SHIFT   (4)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid1),
        .in_ready  (inReady1),
        .a         (aIn1),
        .b         (bIn1),
        .out_valid (outValid1),
        .out_ready (outReady1),
        .out_data  (outData1),
        .out_sat   (outSat1)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Drive one vector into the chosen instance; optionally queue its expected result and check latency.
    task automatic applyStimulus(input int dut, input int n, input vec_t av, input vec_t bv,
                                 input bit gapped, input bit full,
                                 input logic signed [15:0] expData, input logic expSat);
        exp_t e;
        logic rdy;
        bit   accepted;
        e.data = expData;
        e.sat  = expSat;
        if (full) begin
            if (dut == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (gapped && i > 0) begin
                if (dut == 0) inValid0 = 1'b0;
                else          inValid1 = 1'b0;
                @(posedge clk); #1;
            end
            if (dut == 0) begin inValid0 = 1'b1; aIn0 = av[i]; bIn0 = bv[i]; end
            else          begin inValid1 = 1'b1; aIn1 = av[i]; bIn1 = bv[i]; end
            accepted = 1'b0;
            for (int t = 0; t < 20 && !accepted; t++) begin
                @(negedge clk);
                rdy = (dut == 0) ? inReady0 : inReady1;
                if (rdy) accepted = 1'b1;
                @(posedge clk); #1;
            end
            if (dut == 0) inValid0 = 1'b0;
            else          inValid1 = 1'b0;
            if (!accepted) checkOutput("accept_timeout", 0, 1);
        end
        if (full) begin
            @(negedge clk);
            checkOutput("latency_flush_valid", (dut == 0) ? outValid0 : outValid1, 0);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("latency_out_valid", (dut == 0) ? outValid0 : outValid1, 1);
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor for the default instance: compare every valid cycle, pop on handshake.
    always @(negedge clk) begin
        exp_t e0;
        if (!reset && outValid0) begin
            if (q0.size() == 0) begin
                checkOutput("dut0_unexpected_valid", 1, 0);
            end else begin
                e0 = q0[0];
                checkOutput("dut0_out_data", outData0, e0.data);
                checkOutput("dut0_out_sat", outSat0, e0.sat);
                checkOutput("dut0_in_ready_during_out", inReady0, 0);
                if (outReady0) void'(q0.pop_front());
            end
        end
    end

    // Scoreboard monitor for the rounding instance.
    always @(negedge clk) begin
        exp_t e1;
        if (!reset && outValid1) begin
            if (q1.size() == 0) begin
                checkOutput("dut1_unexpected_valid", 1, 0);
            end else begin
                e1 = q1[0];
                checkOutput("dut1_out_data", outData1, e1.data);
                checkOutput("dut1_out_sat", outSat1, e1.sat);
                if (outReady1) void'(q1.pop_front());
            end
        end
    end

    // Directed test sequence.
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        inValid0 = 1'b0; aIn0 = '0; bIn0 = '0; outReady0 = 1'b1;
        inValid1 = 1'b0; aIn1 = '0; bIn1 = '0; outReady1 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("in_ready_during_reset", inReady0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", inReady0, 1);
        checkOutput("reset_out_valid", outValid0, 0);
        checkOutput("reset_out_data", outData0, 0);
        checkOutput("reset_out_sat", outSat0, 0);
        checkOutput("reset_in_ready_dut1", inReady1, 1);
        @(posedge clk); #1;

        $display("[TB] basic back-to-back vector");
        va = '{8'(-5), 8'(-128), 8'(20), 8'(1)};
        vb = '{8'(10), 8'(-1), 8'(15), 8'(0)};
        applyStimulus(0, 4, va, vb, 1'b0, 1'b1, 16'sd378, 1'b0);

        $display("[TB] gapped vector");
        applyStimulus(0, 4, va, vb, 1'b1, 1'b1, 16'sd378, 1'b0);

        $display("[TB] positive saturation");
        va = '{8'(-128), 8'(-128), 8'(-128), 8'(-128)};
        vb = '{8'(-128), 8'(-128), 8'(-128), 8'(-128)};
        applyStimulus(0, 4, va, vb, 1'b0, 1'b1, 16'sd32767, 1'b1);

        $display("[TB] negative saturation");
        vb = '{8'(127), 8'(127), 8'(127), 8'(127)};
        applyStimulus(0, 4, va, vb, 1'b0, 1'b1, -16'sd32768, 1'b1);

        $display("[TB] rounding with SHIFT=4");
        va = '{8'(4), 8'(0), 8'(0), 8'(0)};
        vb = '{8'(6), 8'(0), 8'(0), 8'(0)};
        applyStimulus(1, 1, va, vb, 1'b0, 1'b1, 16'sd2, 1'b0);
        va[0] = 8'(-4);
        applyStimulus(1, 1, va, vb, 1'b0, 1'b1, -16'sd1, 1'b0);
        va[0] = 8'(1);
        vb[0] = 8'(8);
        applyStimulus(1, 1, va, vb, 1'b0, 1'b1, 16'sd1, 1'b0);

        $display("[TB] backpressure on output");
        outReady0 = 1'b0;
        va = '{8'(-5), 8'(-128), 8'(20), 8'(1)};
        vb = '{8'(10), 8'(-1), 8'(15), 8'(0)};
        applyStimulus(0, 4, va, vb, 1'b0, 1'b1, 16'sd378, 1'b0);
        for (int k = 0; k < 3; k++) begin
            inValid0 = (k != 1);
            aIn0 = 8'(77);
            bIn0 = 8'(55);
            @(posedge clk); #1;
        end
        inValid0 = 1'b0;
        @(negedge clk);
        checkOutput("stall_out_valid", outValid0, 1);
        @(posedge clk); #1;
        outReady0 = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_out_valid", outValid0, 0);
        checkOutput("release_in_ready", inReady0, 1);
        va = '{8'(2), 8'(3), 8'(4), 8'(5)};
        vb = '{8'(-1), 8'(2), 8'(-3), 8'(4)};
        applyStimulus(0, 4, va, vb, 1'b0, 1'b1, 16'sd12, 1'b0);

        $display("[TB] reset mid-vector");
        va = '{8'(100), 8'(100), 8'(0), 8'(0)};
        vb = '{8'(100), 8'(100), 8'(0), 8'(0)};
        applyStimulus(0, 2, va, vb, 1'b0, 1'b0, 16'sd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_in_ready", inReady0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_in_ready_after", inReady0, 1);
        checkOutput("midreset_out_data", outData0, 0);
        @(posedge clk); #1;
        va = '{8'(1), 8'(2), 8'(3), 8'(4)};
        vb = '{8'(1), 8'(1), 8'(1), 8'(1)};
        applyStimulus(0, 4, va, vb, 1'b0, 1'b1, 16'sd10, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("dut0_queue_drained", q0.size(), 0);
        checkOutput("dut1_queue_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
